// File: rtl/qam_tx_upsampler.sv
// -----------------------------------------------------------------------------
// qam_tx_upsampler
//
// Sits between the QAM mapper and the pulse-shaping filter. Mapped I/Q symbols
// are buffered in a small FIFO and each one is emitted as SPS output samples:
// either the symbol repeated SPS times (sample-and-hold) or the symbol once
// followed by SPS-1 zero samples (zero-stuffing). The mapper cannot be stalled,
// so a symbol arriving while the FIFO is full is dropped and a sticky overflow
// flag is raised.
//
// Ports
//   clk        : rising-edge clock
//   reset      : asynchronous, active-low reset
//   sym_i      : signed symbol I from the mapper
//   sym_q      : signed symbol Q from the mapper
//   sym_valid  : sym_i/sym_q valid this cycle
//   smp_i      : signed output sample I
//   smp_q      : signed output sample Q
//   smp_valid  : output sample valid
//   smp_ready  : downstream accepts the sample when smp_valid && smp_ready
//   smp_first  : high on the first sample of each symbol
//   overflow   : sticky, set when a symbol is dropped
//   fifo_level : symbols currently held in the FIFO (output register excluded)
// -----------------------------------------------------------------------------
module qam_tx_upsampler #(
    parameter int DW         = 8,
    parameter int SPS        = 4,
    parameter int DEPTH      = 4,
    parameter int ZERO_STUFF = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [DW-1:0]         sym_i,
    input  logic signed [DW-1:0]         sym_q,
    input  logic                         sym_valid,
    output logic signed [DW-1:0]         smp_i,
    output logic signed [DW-1:0]         smp_q,
    output logic                         smp_valid,
    input  logic                         smp_ready,
    output logic                         smp_first,
    output logic                         overflow,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);
    localparam int CW = $clog2(SPS);

    typedef enum logic {IDLE, RUN} state_t;

    // Value shown for samples after the first one of a symbol: the held
    // sample itself, or zero when zero-stuffing.
    function automatic logic signed [DW-1:0] later_sample(input logic signed [DW-1:0] s);
        return (ZERO_STUFF != 0) ? '0 : s;
    endfunction

    logic signed [DW-1:0] mem_i [DEPTH];
    logic signed [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0]        wptr;
    logic [AW-1:0]        rptr;
    logic [CW-1:0]        cnt;

    state_t state;
    state_t state_nxt;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;
    logic load;
    logic advance;
    logic finish;
    logic hs;

    // Fullness is taken from the level before any same-edge pop, so a write
    // into a full FIFO is dropped even when the head leaves on that edge.
    assign fifo_full  = (fifo_level == LW'(DEPTH));
    assign fifo_empty = (fifo_level == '0);
    assign push       = sym_valid && !fifo_full;
    assign hs         = smp_valid && smp_ready;

    // ---- FIFO stage: symbol storage and occupancy ----
    always_ff @(posedge clk) begin
        if (push) begin
            mem_i[wptr] <= sym_i;
            mem_q[wptr] <= sym_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
            if (sym_valid && fifo_full)
                overflow <= 1'b1;
        end
    end

    // ---- Sequencer: IDLE waits for a symbol, RUN walks cnt through SPS samples ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load      = 1'b0;
        advance   = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (hs) begin
                    if (cnt != CW'(SPS-1)) begin
                        advance = 1'b1;
                    end else if (!fifo_empty) begin
                        // Chain straight into the next symbol without a bubble.
                        pop  = 1'b1;
                        load = 1'b1;
                    end else begin
                        finish    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---- Output stage: sample register, held stable while not accepted ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            smp_i     <= '0;
            smp_q     <= '0;
            smp_valid <= 1'b0;
            smp_first <= 1'b0;
            cnt       <= '0;
        end else if (load) begin
            smp_i     <= mem_i[rptr];
            smp_q     <= mem_q[rptr];
            smp_valid <= 1'b1;
            smp_first <= 1'b1;
            cnt       <= '0;
        end else if (advance) begin
            smp_i     <= later_sample(smp_i);
            smp_q     <= later_sample(smp_q);
            smp_first <= 1'b0;
            cnt       <= cnt + 1'b1;
        end else if (finish) begin
            smp_i     <= '0;
            smp_q     <= '0;
            smp_valid <= 1'b0;
            smp_first <= 1'b0;
            cnt       <= '0;
        end
    end

endmodule
